skid_buffer: RTL and testbench
==============================

SKID_BUFFER -- requirements
Module: skid_buffer

Interface
REQ-001 Parameter: N, default 16, data width in bits.
REQ-002 Port: clk  input  1  rising-edge clock; the only clock.
REQ-003 Port: rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 Port: flush  input  1  synchronous clear of buffered data; lower priority than rst.
REQ-005 Port: in_valid  input  1  upstream offers in_data this cycle.
REQ-006 Port: in_data  input  N  upstream data word.
REQ-007 Port: in_ready  output  1  buffer accepts in_data this cycle; registered.
REQ-008 Port: out_valid  output  1  out_data holds a valid word; registered.
REQ-009 Port: out_data  output  N  oldest buffered word; registered.
REQ-010 Port: out_ready  input  1  downstream consumes out_data this cycle.
REQ-011 Port: count  output  2  number of words held (0, 1 or 2); registered.

Function
REQ-012 Transfer rule: input accepted on a rising edge iff in_valid=1 and in_ready=1; output consumed iff out_valid=1 and out_ready=1.
REQ-013 Storage: a main register (drives out_data) and a skid register; words leave in the order they arrived.
REQ-014 States: EMPTY (count=0, out_valid=0, in_ready=1), BUSY (count=1, out_valid=1, in_ready=1), FULL (count=2, out_valid=1, in_ready=0).
REQ-015 EMPTY: in_valid=1 -> main<=in_data, go BUSY; otherwise stay EMPTY; out_ready ignored.
REQ-016 BUSY: in_valid=1 and out_ready=1 -> main<=in_data, stay BUSY (one in, one out per cycle).
REQ-017 BUSY: in_valid=1 and out_ready=0 -> skid<=in_data, go FULL; main unchanged.
REQ-018 BUSY: in_valid=0 and out_ready=1 -> go EMPTY.
REQ-019 BUSY: in_valid=0 and out_ready=0 -> hold everything.
REQ-020 FULL: out_ready=1 -> main<=skid, go BUSY; in_valid ignored this cycle since in_ready=0.
REQ-021 FULL: out_ready=0 -> hold everything; in_data shall not be captured.
REQ-022 Latency: a word accepted into an EMPTY buffer shall appear on out_data with out_valid=1 on the very next cycle.
REQ-023 Throughput: with out_ready held at 1, one word per cycle passes through indefinitely and the buffer never enters FULL.
REQ-024 in_ready shall be a flop output, never combinationally dependent on out_ready.
REQ-025 out_data shall hold its value while out_valid=1 and out_ready=0 (stable until consumed).
REQ-026 When out_valid=0, out_data retains its last value (don't-care to downstream, but no X after reset).
REQ-027 flush=1: next state EMPTY, count=0, out_valid=0, in_ready=1; concurrent in_valid is dropped.
REQ-028 Unreachable state encodings shall recover to EMPTY on the next clock.

Reset
REQ-029 rst=1 at a rising edge: state EMPTY, count=0, out_valid=0, in_ready=1, out_data=0, skid=0.
REQ-030 rst overrides flush, in_valid and out_ready in the same cycle; reset mid-transfer discards all held words.
REQ-031 First acceptance possible on the first rising edge after rst deasserts.

Verification
REQ-032 Reset then in_valid=1, in_data=16'h1234, out_ready=1 for one cycle -> next cycle out_valid=1, out_data=16'h1234, count=1; following cycle count=0.
REQ-033 Stream 16'h0000..16'h00FF with out_ready=1 constantly -> 256 words out in order, in_ready never 0, count never 2.
REQ-034 BUSY holding 16'hAAAA, out_ready=0, push 16'hBBBB -> count=2, in_ready=0; push 16'hCCCC ignored; out_ready=1 for two cycles yields 16'hAAAA then 16'hBBBB, never 16'hCCCC.
REQ-035 FULL with out_ready=1 and in_valid=1 same cycle -> only pop occurs, count=1, out_data=skid word.
REQ-036 FULL, assert flush=1 with in_valid=1 -> next cycle count=0, out_valid=0, in_ready=1; assert rst with flush -> same state plus out_data=0.
REQ-037 Random in_valid/out_ready for 2000 cycles against a reference FIFO model -> zero order or data mismatches, out_data stable whenever stalled.

Source files
------------

// File: rtl/skid_buffer.sv
// skid_buffer: two-entry registered ready/valid skid buffer with flush
module skid_buffer #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [N-1:0] out_data,
  input  logic         out_ready,
  output logic [1:0]   count
);
  typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_t;
  state_t state, nxt;
  logic [N-1:0] skid, main_n, skid_n;
  always_comb begin
    nxt = EMPTY;
    main_n = out_data;
    skid_n = skid;
    case (state)
      EMPTY: begin
        nxt = in_valid ? BUSY : EMPTY;
        main_n = in_valid ? in_data : out_data;
      end
      BUSY: begin
        nxt = in_valid ? (out_ready ? BUSY : FULL) : (out_ready ? EMPTY : BUSY);
        main_n = in_valid && out_ready ? in_data : out_data;
        skid_n = in_valid && !out_ready ? in_data : skid;
      end
      FULL: begin
        nxt = out_ready ? BUSY : FULL;
        main_n = out_ready ? skid : out_data;
      end
      default: nxt = EMPTY;
    endcase
    if (flush) begin
      nxt = EMPTY;
      main_n = out_data;
      skid_n = skid;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      out_data <= '0;
      skid <= '0;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      count <= 2'd0;
    end else begin
      state <= nxt;
      out_data <= main_n;
      skid <= skid_n;
      in_ready <= nxt != FULL;
      out_valid <= nxt != EMPTY;
      count <= nxt == FULL ? 2'd2 : nxt == BUSY ? 2'd1 : 2'd0;
    end
  end
endmodule

// File: tb/tb_skid_buffer.sv
// tb_skid_buffer: scoreboard bench for skid_buffer
module tb_skid_buffer;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [15:0] in_data = '0, out_data;
  logic in_ready, out_valid;
  logic [1:0] count;
  logic [15:0] q[$];
  int n_chk = 0, n_fail = 0;
  logic stalled = 0;
  logic [15:0] last = '0;
  skid_buffer #(.N(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .count(count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(input logic iv, input logic [15:0] d, input logic ordy);
    in_valid = iv;
    in_data = d;
    out_ready = ordy;
    @(negedge clk);
    if (in_valid && in_ready && !rst && !flush) q.push_back(in_data);
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (rst || flush) stalled <= 0;
    else begin
      if (stalled) chk("stable", {16'h0, out_data}, {16'h0, last});
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_word", {16'h0, out_data}, 32'hFFFF_FFFF);
        else chk("data_order", {16'h0, out_data}, {16'h0, q.pop_front()});
      end
      stalled <= out_valid && !out_ready;
      last <= out_data;
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: time %0t limit reached", $time);
    $fatal(1, "timeout");
  end
  initial begin
    drive(0, 0, 0);
    drive(0, 0, 0);
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
    rst = 0;
    drive(1, 16'h1234, 1);
    chk("lat_out_valid", out_valid, 1);
    chk("lat_out_data", out_data, 16'h1234);
    chk("lat_count", count, 1);
    drive(0, 0, 1);
    chk("lat_count_after", count, 0);
    for (int i = 0; i < 256; i++) begin
      drive(1, 16'(i), 1);
      chk("stream_in_ready", in_ready, 1);
      chk("stream_not_full", count == 2, 0);
    end
    drive(0, 0, 1);
    chk("stream_drained", count, 0);
    chk("stream_queue", q.size(), 0);
    drive(1, 16'hAAAA, 0);
    chk("skid_count1", count, 1);
    drive(1, 16'hBBBB, 0);
    chk("skid_count2", count, 2);
    chk("skid_in_ready", in_ready, 0);
    drive(1, 16'hCCCC, 0);
    chk("skid_hold_count", count, 2);
    chk("skid_hold_data", out_data, 16'hAAAA);
    drive(0, 0, 1);
    chk("skid_pop1_count", count, 1);
    chk("skid_pop1_data", out_data, 16'hBBBB);
    drive(0, 0, 1);
    chk("skid_pop2_count", count, 0);
    drive(1, 16'h1111, 0);
    drive(1, 16'h2222, 0);
    drive(1, 16'h3333, 1);
    chk("full_pop_count", count, 1);
    chk("full_pop_data", out_data, 16'h2222);
    chk("full_pop_in_ready", in_ready, 1);
    drive(0, 0, 1);
    drive(1, 16'h4444, 0);
    drive(1, 16'h5555, 0);
    flush = 1;
    drive(1, 16'h6666, 0);
    flush = 0;
    q.delete();
    chk("flush_count", count, 0);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    drive(1, 16'h7777, 0);
    drive(1, 16'h8888, 0);
    rst = 1;
    flush = 1;
    drive(1, 16'h9999, 1);
    rst = 0;
    flush = 0;
    q.delete();
    chk("rstflush_count", count, 0);
    chk("rstflush_out_valid", out_valid, 0);
    chk("rstflush_in_ready", in_ready, 1);
    chk("rstflush_out_data", out_data, 0);
    drive(1, 16'hABCD, 0);
    chk("first_accept_count", count, 1);
    chk("first_accept_data", out_data, 16'hABCD);
    for (int i = 0; i < 2000; i++) begin
      drive(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
      chk("rand_count", count, q.size());
    end
    repeat (3) drive(0, 0, 1);
    chk("final_count", count, 0);
    chk("final_queue", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
